// File: rtl/camera_pingpong_buffer_ctrl.sv
// Ping-pong bank scheduler for the camera line RAM: one bank fills from the pixel
// packer while the other drains to the bus master.
module camera_pingpong_buffer_ctrl #(
   parameter int nrOfEntries = 512,
   localparam int AW = $clog2(nrOfEntries),
   localparam int CW = AW,
   localparam int B = nrOfEntries / 2
) (
   input  logic          clock,
   input  logic          nReset,
   input  logic [31:0]   pixelWordIn,
   input  logic          pixelWordValid,
   input  logic          lineEnd,
   output logic          overflow,
   output logic          bankReady,
   output logic [CW-1:0] bankWords,
   input  logic          readStart,
   output logic          readBusy,
   output logic [31:0]   readData,
   output logic          readValid,
   output logic          readLast,
   output logic [AW-1:0] ramAddress1,
   output logic          ramWriteEnable,
   output logic [31:0]   ramDataIn1,
   output logic [AW-1:0] ramAddress2,
   input  logic [31:0]   ramDataOut2
);

   typedef enum logic {IDLE, READ} rdState_t;

   rdState_t      rdState, rdNext;
   logic          writeBank, readBank;
   logic [CW-1:0] writeCount, count0, count1, readLen;
   logic [1:0]    full, fullNext;
   logic [AW-2:0] readIndex;
   logic          validPipe, lastPipe, overflowReg;

   logic          accept, drop, closeBank, startRead, lastIssue;
   logic [CW-1:0] nextCount, closeCount, headCount, lastIdx;

   assign accept     = pixelWordValid & ~full[writeBank];
   assign drop       = pixelWordValid & full[writeBank];
   assign nextCount  = writeCount + 1'b1;
   assign closeCount = accept ? nextCount : writeCount;
   // A dropped word also swallows any lineEnd arriving with it.
   assign closeBank  = accept ? ((nextCount == CW'(B)) | lineEnd)
                              : (~pixelWordValid & lineEnd & (writeCount != '0));
   assign headCount  = readBank ? count1 : count0;
   assign lastIdx    = readLen - 1'b1;
   assign lastIssue  = (rdState == READ) && ({1'b0, readIndex} == lastIdx);
   // validPipe blocks a restart in the tail cycle before the bank is released.
   assign startRead  = readStart & full[readBank] & ~validPipe;

   always_comb begin
      fullNext = full;
      if (closeBank)
         fullNext[writeBank] = 1'b1;
      if (lastPipe)
         fullNext[readBank] = 1'b0;
   end

   always_comb begin
      rdNext = rdState;
      case (rdState)
         IDLE: if (startRead) rdNext = READ;
         READ: if (lastIssue) rdNext = IDLE;
         default: rdNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         writeBank   <= 1'b0;
         writeCount  <= '0;
         count0      <= '0;
         count1      <= '0;
         full        <= 2'b00;
         overflowReg <= 1'b0;
      end else begin
         overflowReg <= drop;
         full        <= fullNext;
         if (closeBank) begin
            writeCount <= '0;
            writeBank  <= ~writeBank;
            if (writeBank)
               count1 <= closeCount;
            else
               count0 <= closeCount;
         end else if (accept) begin
            writeCount <= nextCount;
         end
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         rdState   <= IDLE;
         readBank  <= 1'b0;
         readIndex <= '0;
         readLen   <= '0;
         validPipe <= 1'b0;
         lastPipe  <= 1'b0;
      end else begin
         rdState   <= rdNext;
         validPipe <= (rdState == READ);
         lastPipe  <= lastIssue;
         if (rdState == IDLE && startRead) begin
            readLen   <= headCount;
            readIndex <= '0;
         end else if (rdState == READ) begin
            readIndex <= readIndex + 1'b1;
         end
         if (lastPipe)
            readBank <= ~readBank;
      end
   end

   assign overflow       = overflowReg;
   assign bankReady      = full[readBank];
   assign bankWords      = full[readBank] ? headCount : '0;
   assign readBusy       = (rdState == READ) | validPipe;
   assign readData       = ramDataOut2;
   assign readValid      = validPipe;
   assign readLast       = lastPipe;
   assign ramAddress1    = {writeBank, writeCount[AW-2:0]};
   assign ramWriteEnable = accept;
   assign ramDataIn1     = pixelWordIn;
   assign ramAddress2    = {readBank, (rdState == READ) ? readIndex : {(AW-1){1'b0}}};

endmodule

// File: tb/tb_camera_pingpong_buffer_ctrl.sv
// Scoreboard bench for camera_pingpong_buffer_ctrl with a behavioural 512x32 RAM
// that has registered read data.
module tb_camera_pingpong_buffer_ctrl;

   localparam int nrOfEntries = 512;
   localparam int AW = 9;
   localparam int CW = 9;

   logic          clock = 1'b0;
   logic          nReset = 1'b0;
   logic [31:0]   pixelWordIn = '0;
   logic          pixelWordValid = 1'b0;
   logic          lineEnd = 1'b0;
   logic          readStart = 1'b0;
   logic          overflow, bankReady, readBusy, readValid, readLast, ramWriteEnable;
   logic [CW-1:0] bankWords;
   logic [31:0]   readData, ramDataIn1;
   logic [31:0]   ramDataOut2 = '0;
   logic [AW-1:0] ramAddress1, ramAddress2;

   logic [31:0]   mem [nrOfEntries];

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t expQ[$];
   exp_t popped;
   int   total = 0;
   int   bad = 0;
   int   overflowCount = 0;
   bit   ignoreRead = 0;

   camera_pingpong_buffer_ctrl #(.nrOfEntries(nrOfEntries)) dut (
      .clock(clock),
      .nReset(nReset),
      .pixelWordIn(pixelWordIn),
      .pixelWordValid(pixelWordValid),
      .lineEnd(lineEnd),
      .overflow(overflow),
      .bankReady(bankReady),
      .bankWords(bankWords),
      .readStart(readStart),
      .readBusy(readBusy),
      .readData(readData),
      .readValid(readValid),
      .readLast(readLast),
      .ramAddress1(ramAddress1),
      .ramWriteEnable(ramWriteEnable),
      .ramDataIn1(ramDataIn1),
      .ramAddress2(ramAddress2),
      .ramDataOut2(ramDataOut2)
   );

   always #5 clock = ~clock;

   // Dual-port RAM model, both ports on the same clock, one-cycle read latency.
   always @(posedge clock) begin
      if (ramWriteEnable)
         mem[ramAddress1] <= ramDataIn1;
      ramDataOut2 <= mem[ramAddress2];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Monitor pops one expectation for every word the DUT presents.
   always @(negedge clock) begin
      if (nReset && overflow)
         overflowCount++;
      if (nReset && readValid && !ignoreRead) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedRead: got data %0h expected no word", readData);
         end else begin
            popped = expQ.pop_front();
            checkOutput("readData", readData, popped.data);
            checkOutput("readLast", 32'(readLast), 32'(popped.last));
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] base, input int n, input logic flush,
                                input logic [AW-1:0] firstAddr);
      for (int i = 0; i < n; i++) begin
         pixelWordIn    = base + i;
         pixelWordValid = 1'b1;
         lineEnd        = flush && (i == n - 1);
         if (i == 0) begin
            #1;
            checkOutput("fillAddr", 32'(ramAddress1), 32'(firstAddr));
            checkOutput("fillWe", 32'(ramWriteEnable), 32'd1);
         end
         @(posedge clock); #1;
      end
      pixelWordValid = 1'b0;
      lineEnd        = 1'b0;
   endtask

   task automatic startDrain(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++)
         expQ.push_back(exp_t'{data: base + i, last: (i == n - 1)});
      readStart = 1'b1;
      @(posedge clock); #1;
      readStart = 1'b0;
   endtask

   task automatic waitIdle();
      int cycles = 0;
      while (readBusy && cycles < 2000) begin
         @(posedge clock); #1;
         cycles++;
      end
      if (readBusy) begin
         total++;
         bad++;
         $display("[TB] FAIL drainTimeout: got readBusy=1 expected 0 within 2000 cycles");
      end
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
   endtask

   task automatic checkResetState();
      checkOutput("rstBankReady", 32'(bankReady), 32'd0);
      checkOutput("rstBankWords", 32'(bankWords), 32'd0);
      checkOutput("rstReadBusy", 32'(readBusy), 32'd0);
      checkOutput("rstReadValid", 32'(readValid), 32'd0);
      checkOutput("rstReadLast", 32'(readLast), 32'd0);
      checkOutput("rstOverflow", 32'(overflow), 32'd0);
      checkOutput("rstAddr1", 32'(ramAddress1), 32'd0);
      checkOutput("rstAddr2", 32'(ramAddress2), 32'd0);
      checkOutput("rstWe", 32'(ramWriteEnable), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      checkResetState();
      nReset = 1'b1;
      @(posedge clock); #1;

      $display("[TB] full bank fill and drain");
      applyStimulus(32'h0, 256, 1'b0, 9'd0);
      checkOutput("fullBankReady", 32'(bankReady), 32'd1);
      checkOutput("fullBankWords", 32'(bankWords), 32'd256);
      startDrain(32'h0, 256);
      waitIdle();
      checkOutput("fullReleased", 32'(bankReady), 32'd0);

      $display("[TB] partial flush");
      applyStimulus(32'h100, 10, 1'b1, 9'd256);
      checkOutput("partialWords", 32'(bankWords), 32'd10);
      lineEnd = 1'b1;
      @(posedge clock); #1;
      lineEnd = 1'b0;
      @(posedge clock); #1;
      checkOutput("emptyLineEnd", 32'(bankWords), 32'd10);
      startDrain(32'h100, 10);
      @(negedge clock);
      checkOutput("latBusy", 32'(readBusy), 32'd1);
      checkOutput("latNoValid", 32'(readValid), 32'd0);
      @(negedge clock);
      checkOutput("latFirstValid", 32'(readValid), 32'd1);
      @(posedge clock); #1;
      waitIdle();
      checkOutput("noEmptyBank", 32'(bankReady), 32'd0);

      $display("[TB] readStart with no bank ready");
      readStart = 1'b1;
      @(posedge clock); #1;
      readStart = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      checkOutput("idleStart", 32'(readBusy), 32'd0);

      $display("[TB] ping-pong fill while draining");
      applyStimulus(32'h1000, 256, 1'b0, 9'd0);
      overflowCount = 0;
      fork
         begin
            startDrain(32'h1000, 256);
            repeat (3) @(posedge clock);
            #1;
            readStart = 1'b1;
            @(posedge clock); #1;
            readStart = 1'b0;
            waitIdle();
         end
         begin
            applyStimulus(32'h2000, 256, 1'b0, 9'd256);
         end
      join
      checkOutput("pingReady", 32'(bankReady), 32'd1);
      checkOutput("pingWords", 32'(bankWords), 32'd256);
      checkOutput("pingNoOverflow", 32'(overflowCount), 32'd0);
      startDrain(32'h2000, 256);
      waitIdle();

      $display("[TB] overflow with both banks full");
      applyStimulus(32'h3000, 256, 1'b0, 9'd0);
      applyStimulus(32'h4000, 256, 1'b0, 9'd256);
      overflowCount = 0;
      pixelWordIn    = 32'hDEADBEEF;
      pixelWordValid = 1'b1;
      #1;
      checkOutput("ovfWe", 32'(ramWriteEnable), 32'd0);
      @(posedge clock); #1;
      pixelWordValid = 1'b0;
      checkOutput("ovfPulse", 32'(overflow), 32'd1);
      @(posedge clock); #1;
      checkOutput("ovfPulseEnd", 32'(overflow), 32'd0);
      checkOutput("ovfCount", 32'(overflowCount), 32'd1);
      checkOutput("ovfWords", 32'(bankWords), 32'd256);
      startDrain(32'h3000, 256);
      waitIdle();
      startDrain(32'h4000, 256);
      waitIdle();
      checkOutput("ovfDrained", 32'(bankReady), 32'd0);

      $display("[TB] reset mid-fill and mid-drain");
      applyStimulus(32'h5000, 256, 1'b0, 9'd0);
      applyStimulus(32'h6000, 5, 1'b0, 9'd256);
      ignoreRead = 1;
      readStart = 1'b1;
      @(posedge clock); #1;
      readStart = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      nReset = 1'b0;
      #1;
      checkResetState();
      @(posedge clock); #1;
      nReset = 1'b1;
      ignoreRead = 0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("postRstValid", 32'(readValid), 32'd0);
      checkOutput("postRstReady", 32'(bankReady), 32'd0);
      applyStimulus(32'h7000, 3, 1'b1, 9'd0);
      checkOutput("postRstWords", 32'(bankWords), 32'd3);
      startDrain(32'h7000, 3);
      waitIdle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
